// File: rtl/ac_motor_dead_time.sv
// Dead-time insertion stage for a three-leg inverter bridge.
// Each leg turns its s1..s3 command into complementary high/low gate drives.
// Both gates of a leg stay off for DEAD_CYCLES clocks around every transition.
// A global enable and a latched fault force every gate off.
module ac_motor_dead_time #(
    parameter int unsigned DEAD_CYCLES = 50,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fault,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    output logic [2:0] gh,
    output logic [2:0] gl,
    output logic       fault_lat
);

    typedef enum logic [2:0] {
        OFF,
        DT_H,
        HI,
        DT_L,
        LO
    } leg_state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEAD_CYCLES - 1);

    leg_state_t       state     [3];
    leg_state_t       state_nxt [3];
    logic [CNT_W-1:0] cnt       [3];
    logic [CNT_W-1:0] cnt_nxt   [3];
    logic [2:0]       gh_nxt;
    logic [2:0]       gl_nxt;
    logic [2:0]       cmd;
    logic             go;

    assign cmd = {s3, s2, s1};
    assign go  = enable & ~fault_lat & ~fault;

    // Per-leg next state, dead-time counter and gate drive, derived from the next state
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            gh_nxt[i]    = 1'b0;
            gl_nxt[i]    = 1'b0;

            if (!go) begin
                state_nxt[i] = OFF;
                cnt_nxt[i]   = '0;
            end else begin
                case (state[i])
                    OFF: begin
                        state_nxt[i] = cmd[i] ? DT_H : DT_L;
                        cnt_nxt[i]   = RELOAD;
                    end
                    LO: begin
                        if (cmd[i]) begin
                            state_nxt[i] = DT_H;
                            cnt_nxt[i]   = RELOAD;
                        end
                    end
                    HI: begin
                        if (!cmd[i]) begin
                            state_nxt[i] = DT_L;
                            cnt_nxt[i]   = RELOAD;
                        end
                    end
                    DT_H: begin
                        // A reversal restarts the full dead time toward the other side
                        if (!cmd[i]) begin
                            state_nxt[i] = DT_L;
                            cnt_nxt[i]   = RELOAD;
                        end else if (cnt[i] == '0) begin
                            state_nxt[i] = HI;
                        end else begin
                            cnt_nxt[i] = cnt[i] - 1'b1;
                        end
                    end
                    DT_L: begin
                        if (cmd[i]) begin
                            state_nxt[i] = DT_H;
                            cnt_nxt[i]   = RELOAD;
                        end else if (cnt[i] == '0) begin
                            state_nxt[i] = LO;
                        end else begin
                            cnt_nxt[i] = cnt[i] - 1'b1;
                        end
                    end
                    default: begin
                        state_nxt[i] = OFF;
                        cnt_nxt[i]   = '0;
                    end
                endcase
            end

            gh_nxt[i] = (state_nxt[i] == HI);
            gl_nxt[i] = (state_nxt[i] == LO);
        end
    end

    // State, counters, registered gate outputs and fault latch
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state[i] <= OFF;
                cnt[i]   <= '0;
            end
            gh        <= '0;
            gl        <= '0;
            fault_lat <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            gh        <= gh_nxt;
            gl        <= gl_nxt;
            fault_lat <= fault_lat | fault;
        end
    end

endmodule
